// File: rtl/sw_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sw_conditioner
// Description : Slide-switch input conditioner for the password verifier.
//               Each raw switch is brought into the clk domain by a two-flop
//               synchronizer and then debounced. A new level is accepted only
//               after it has been stable for DEBOUNCE_CYCLES consecutive
//               cycles. Each accepted 0->1 transition becomes a single-cycle
//               pulse on sw_pulse. Holding a switch therefore reads as one
//               "digit" followed by zeros. sw_level carries the debounced
//               levels for LED display.
//
//               Optional build macro SW_CONDITIONER_RELEASE_EN:
//                 defined   - an 'armed' flag gates every pulse. The first
//                             pulse clears it, and it re-arms only once all
//                             debounced levels are back at zero. Rising
//                             edges accepted while disarmed are dropped.
//                 undefined - every debounced rising edge pulses.
//
// Ports       : clk      in  1      system clock, rising edge
//               rst      in  1      asynchronous active-low reset
//               sw_raw   in  WIDTH  raw asynchronous switch levels
//               sw_pulse out WIDTH  registered one-cycle rising-edge pulses
//               sw_level out WIDTH  registered debounced levels
//
// Parameters  : WIDTH           number of switches
//               DEBOUNCE_CYCLES stable cycles needed to accept a level (>=1)
//               CNT_W           debounce counter width (holds DEBOUNCE_CYCLES-1)
//
// Revision    : 1.0  initial release
// ============================================================================
module sw_conditioner #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_pulse,
    output logic [WIDTH-1:0] sw_level
);

    // Terminal count. Once a differing level has been seen for this many
    // consecutive cycles, the next edge accepts it.
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Two-flop synchronizer (all bits share the same register pair)
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_raw;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-bit debounce. The bits are fully independent. The stable level and
    // the counter live inside each generate iteration so that every register
    // has exactly one driver.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_stb;     // debounced levels
    logic [WIDTH-1:0] w_rise;    // this edge accepts a 0->1 change

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            logic             r_stb;
            logic             w_diff;
            logic             w_at_max;

            assign w_diff   = r_s2[gi] ^ r_stb;
            assign w_at_max = (r_cnt == C_CNT_MAX);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= '0;
                    r_stb <= 1'b0;
                end else if (!w_diff) begin
                    // Synchronized level agrees with the stable level. Any
                    // glitch that returned here restarts the count.
                    r_cnt <= '0;
                end else if (w_at_max) begin
                    // Stable long enough. Accept the level and rearm the
                    // counter. The counter never goes past C_CNT_MAX.
                    r_cnt <= '0;
                    r_stb <= r_s2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_stb[gi]  = r_stb;
            // A rising edge is an accept where the new level is 1.
            assign w_rise[gi] = w_diff & w_at_max & r_s2[gi];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pulse generation (optionally gated by the release requirement)
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_pulse_next;
    logic [WIDTH-1:0] r_pulse;

`ifdef SW_CONDITIONER_RELEASE_EN
    logic r_armed;

    // Several bits accepted on one edge pass through together while armed.
    // Rejecting multi-bit digits is the verifier's job.
    assign w_pulse_next = w_rise & {WIDTH{r_armed}};

    // The pulse has priority over re-arming. w_stb is the registered level,
    // so re-arming happens on the edge after the levels reach all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed <= 1'b1;
        end else if (|w_pulse_next) begin
            r_armed <= 1'b0;
        end else if (w_stb == '0) begin
            r_armed <= 1'b1;
        end
    end
`else
    assign w_pulse_next = w_rise;
`endif

    // The pulse registers on the same edge that updates the stable level, so
    // sw_pulse and sw_level rise together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_pulse_next;
        end
    end

    assign sw_pulse = r_pulse;
    assign sw_level = w_stb;

endmodule
`default_nettype wire
